// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 compression core.
// Contents: controller state enum, round/ROM geometry, message word count,
// the first round constant K[0] (reset value of k_t) and the initial hash value.
package sha256_pkg;

    localparam int NUM_ROUNDS = 64;
    localparam int K_PER_ROW  = 8;
    localparam int MSG_WORDS  = 16;

    localparam logic [31:0]  K0 = 32'h428a2f98;
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

endpackage

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: round sequencer for the SHA-256 compression core.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   blk_valid, blk_first, hold    block request, first-block flag, datapath stall
//   blk_ready, busy               accept indication (IDLE and not held), not-IDLE
//   krom_addr, krom_k0..krom_k7   K-ROM row address and the 8 returned words
//   load_en, init_h               load a..h (from IV when init_h)
//   round_en, round_idx, k_t,     one compression round t with K[t] and
//   w_from_msg                    message-vs-schedule W select
//   final_en, done                add a..h into H, digest valid pulse
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
    parameter int K_PER_ROW  = sha256_pkg::K_PER_ROW
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        blk_valid,
    input  logic        blk_first,
    output logic        blk_ready,
    input  logic        hold,
    output logic [3:0]  krom_addr,
    input  logic [31:0] krom_k0,
    input  logic [31:0] krom_k1,
    input  logic [31:0] krom_k2,
    input  logic [31:0] krom_k3,
    input  logic [31:0] krom_k4,
    input  logic [31:0] krom_k5,
    input  logic [31:0] krom_k6,
    input  logic [31:0] krom_k7,
    output logic        load_en,
    output logic        init_h,
    output logic        round_en,
    output logic [5:0]  round_idx,
    output logic [31:0] k_t,
    output logic        w_from_msg,
    output logic        final_en,
    output logic        done,
    output logic        busy
);
    import sha256_pkg::*;

    localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

    state_t      state, nstate;
    logic [5:0]  t, nt, p, np;
    logic [31:0] row [8];

    // Round index whose constant is latched into k_t at the end of a cycle
    // spent in state s with counter x. DONE prefetches K[0] so k_t is back to
    // its reset value once IDLE is reached.
    function automatic logic [5:0] prefetch(input state_t s, input logic [5:0] x);
        return (s == ROUND && x != LAST) ? x + 6'd1 : (s == ROUND || s == FINAL) ? x : 6'd0;
    endfunction

    always_comb begin
        nstate = state;
        nt     = t;
        case (state)
            IDLE:    if (blk_valid) begin
                         nstate = LOAD;
                         nt     = '0;
                     end
            LOAD:    nstate = ROUND;
            ROUND:   begin
                         nstate = (t == LAST) ? FINAL : ROUND;
                         nt     = (t == LAST) ? t : t + 6'd1;
                     end
            FINAL:   nstate = DONE;
            default: nstate = IDLE;
        endcase
    end

    assign row = '{krom_k0, krom_k1, krom_k2, krom_k3, krom_k4, krom_k5, krom_k6, krom_k7};
    assign p   = prefetch(state, t);
    assign np  = prefetch(nstate, nt);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else if (!hold)
            state <= nstate;

    // krom_addr is registered one step ahead: it carries the row needed by the
    // prefetch of the following cycle, so the ROM output is settled when k_t
    // samples it. Under hold everything freezes, keeping that pairing intact.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            t          <= '0;
            krom_addr  <= '0;
            k_t        <= K0;
            init_h     <= 1'b0;
            w_from_msg <= 1'b0;
        end else if (!hold) begin
            t          <= nt;
            krom_addr  <= 4'(np / 6'(K_PER_ROW));
            k_t        <= row[3'(p % 6'(K_PER_ROW))];
            w_from_msg <= nstate == ROUND && nt < 6'(MSG_WORDS);
            if (state == IDLE && blk_valid)
                init_h <= blk_first;
        end

    assign round_idx = t;
    assign load_en   = state == LOAD  && !hold;
    assign round_en  = state == ROUND && !hold;
    assign final_en  = state == FINAL && !hold;
    assign done      = state == DONE  && !hold;
    assign blk_ready = state == IDLE  && !hold;
    assign busy      = state != IDLE;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: scoreboard bench for sha256_round_ctrl with a model K ROM.
module tb_sha256_round_ctrl;

    logic        clk = 1'b0, rst_n = 1'b0, blk_valid = 1'b0, blk_first = 1'b0, hold = 1'b0;
    logic        blk_ready, load_en, init_h, round_en, w_from_msg, final_en, done, busy;
    logic [3:0]  krom_addr;
    logic [5:0]  round_idx;
    logic [31:0] k_t, krom_k0, krom_k1, krom_k2, krom_k3, krom_k4, krom_k5, krom_k6, krom_k7;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    always #5 clk = ~clk;

    assign krom_k0 = k_tab[{krom_addr[2:0], 3'd0}];
    assign krom_k1 = k_tab[{krom_addr[2:0], 3'd1}];
    assign krom_k2 = k_tab[{krom_addr[2:0], 3'd2}];
    assign krom_k3 = k_tab[{krom_addr[2:0], 3'd3}];
    assign krom_k4 = k_tab[{krom_addr[2:0], 3'd4}];
    assign krom_k5 = k_tab[{krom_addr[2:0], 3'd5}];
    assign krom_k6 = k_tab[{krom_addr[2:0], 3'd6}];
    assign krom_k7 = k_tab[{krom_addr[2:0], 3'd7}];

    sha256_round_ctrl dut (
        .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_first(blk_first),
        .blk_ready(blk_ready), .hold(hold), .krom_addr(krom_addr),
        .krom_k0(krom_k0), .krom_k1(krom_k1), .krom_k2(krom_k2), .krom_k3(krom_k3),
        .krom_k4(krom_k4), .krom_k5(krom_k5), .krom_k6(krom_k6), .krom_k7(krom_k7),
        .load_en(load_en), .init_h(init_h), .round_en(round_en), .round_idx(round_idx),
        .k_t(k_t), .w_from_msg(w_from_msg), .final_en(final_en), .done(done), .busy(busy));

    // Expected strobe events: 0 load, 1 round t, 2 final, 3 done.
    typedef struct {
        int   kind;
        int   t;
        logic first;
    } ev_t;

    ev_t  exp_q [$];
    ev_t  e;
    int   compared = 0, mismatched = 0;
    int   cyc = 0, hs_cyc = 0, done_cyc = -100, held = 0, accepts = 0, nstb = 0, kind = 0;
    bit   in_flight = 1'b0, rand_on = 1'b0;
    logic rdy_m;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        compared++;
        if (a !== x) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    // Monitor and reference model: a block is accepted when the source offers
    // it while no block is in flight and no hold is applied; an accepted block
    // must then produce load, rounds 0..63, final and done in order, with done
    // 67 cycles after the handshake plus one cycle per held cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            in_flight = 1'b0;
        end else begin
            rdy_m = !in_flight && !hold;
            chk("blk_ready", 32'(blk_ready), 32'(rdy_m));
            chk("busy", 32'(busy), 32'(in_flight));
            nstb = 32'(load_en) + 32'(round_en) + 32'(final_en) + 32'(done);
            if (hold)
                chk("held_strobes", nstb, 0);
            if (nstb > 1)
                chk("one_strobe", nstb, 1);
            else if (nstb == 1 && exp_q.size() == 0)
                chk("unexpected_strobe", nstb, 0);
            else if (nstb == 1) begin
                e    = exp_q.pop_front();
                kind = done ? 3 : final_en ? 2 : round_en ? 1 : 0;
                chk("event_kind", kind, e.kind);
                if (kind == 0 && e.kind == 0) begin
                    chk("init_h", 32'(init_h), 32'(e.first));
                    chk("load_krom_addr", 32'(krom_addr), 0);
                end
                if (kind == 1 && e.kind == 1) begin
                    chk("round_idx", 32'(round_idx), e.t);
                    chk("k_t", k_t, k_tab[e.t]);
                    chk("w_from_msg", 32'(w_from_msg), 32'(e.t < 16));
                    if (e.t < 63)
                        chk("krom_addr_lead", 32'(krom_addr), (e.t + 1) / 8);
                end
                if (kind == 3 && e.kind == 3) begin
                    chk("done_latency", cyc - hs_cyc, 67 + held);
                    done_cyc  = cyc;
                    in_flight = 1'b0;
                end
            end
            if (in_flight && hold)
                held++;
            if (blk_valid && rdy_m) begin
                exp_q.push_back(ev_t'{0, 0, blk_first});
                for (int t = 0; t < 64; t++)
                    exp_q.push_back(ev_t'{1, t, 1'b0});
                exp_q.push_back(ev_t'{2, 0, 1'b0});
                exp_q.push_back(ev_t'{3, 0, 1'b0});
                hs_cyc    = cyc;
                held      = 0;
                in_flight = 1'b1;
                accepts++;
            end
        end
    end

    task automatic chk_rst(input string n);
        chk({n, "_flags"}, 32'({blk_ready, busy, load_en, round_en, final_en, done, init_h, w_from_msg}), 32'h80);
        chk({n, "_idx_addr"}, 32'({round_idx, krom_addr}), 0);
        chk({n, "_k_t"}, k_t, 32'h428a2f98);
    endtask

    task automatic send(input logic f, input logic keep);
        int a0;
        @(posedge clk);
        #1;
        a0        = accepts;
        blk_valid = 1'b1;
        blk_first = f;
        for (int i = 0; i < 400 && accepts == a0; i++)
            @(posedge clk);
        chk("accept_timeout", 32'(accepts != a0), 1);
        #1;
        if (!keep)
            blk_valid = 1'b0;
    endtask

    task automatic wait_round(input int n);
        bit f = 1'b0;
        for (int i = 0; i < 300 && !f; i++) begin
            @(negedge clk);
            f = round_en && round_idx == 6'(n);
        end
        chk("wait_round", 32'(f), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && (in_flight || exp_q.size() != 0); i++)
            @(posedge clk);
        chk("drain", exp_q.size() + 32'(in_flight), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_rst("reset");
        rst_n = 1'b1;
        // single first block, hold at t=15 and in FINAL
        send(1'b1, 1'b0);
        wait_round(14);
        @(posedge clk);
        #1 hold = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_t15", 32'({round_idx, round_en, w_from_msg}), 32'({6'd15, 1'b0, 1'b1}));
        end
        @(posedge clk);
        #1 hold = 1'b0;
        wait_round(63);
        @(posedge clk);
        #1 hold = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_final", 32'({final_en, done, busy}), 32'b001);
        end
        @(posedge clk);
        #1 hold = 1'b0;
        wait_idle();
        // valid offered during ROUND must be ignored
        send(1'b1, 1'b0);
        wait_round(40);
        @(posedge clk);
        #1 blk_valid = 1'b1;
        blk_first = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("probe_ready_busy", 32'({blk_ready, busy}), 32'b01);
        end
        @(posedge clk);
        #1 blk_valid = 1'b0;
        wait_idle();
        // back-to-back
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        chk("b2b_accept", hs_cyc, done_cyc + 1);
        wait_idle();
        // reset mid-block
        send(1'b1, 1'b0);
        wait_round(30);
        #2 rst_n = 1'b0;
        #1 chk_rst("midreset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(1'b0, 1'b0);
        wait_idle();
        // randomized blocks under random hold
        rand_on = 1'b1;
        fork
            while (rand_on) begin
                @(posedge clk);
                #1 hold = ($urandom_range(0, 5) == 0);
            end
            begin
                for (int b = 0; b < 8; b++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    send(1'($urandom_range(0, 1)), 1'b0);
                end
                wait_idle();
                rand_on = 1'b0;
            end
        join
        hold = 1'b0;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
